stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer. It takes one upstream valid/ready stream and distributes each accepted word to one of N downstream channels. The destination is either a round-robin pointer or an explicit select input. It is the distributing counterpart of the mux-based selection blocks in the combinational section, and it is the building block for fan-out stages in the sequential exercises.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- N, 4, number of downstream channels (≥2)
- SW, $clog2(N), select/pointer width (derived, not overridden)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- up_valid  input  1  upstream word available
- up_data  input  WIDTH  upstream word
- up_ready  output  1  block accepts up_data this cycle
- fixed_en  input  1  1: route to fixed_sel; 0: route to round-robin pointer
- fixed_sel  input  SW  explicit destination channel when fixed_en=1
- down_valid  output  N  bit k: channel k holds a word
- down_data  output  N*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
- down_ready  input  N  bit k: consumer of channel k takes the word this cycle
- rr_ptr  output  SW  current round-robin pointer (observability)

## Operation
- State:
  - per-channel holding register `slot[k]` (WIDTH bits) and `full[k]`
  - round-robin pointer `ptr`
- Destination: `dst = fixed_en ? fixed_sel : ptr`. If fixed_sel ≥ N, up_ready=0 and nothing is accepted.
- Outputs:
  - down_valid[k] = full[k]
  - down_data slice k = slot[k]
  - rr_ptr = ptr
- up_ready = (dst < N) & (~full[dst] | down_ready[dst]). This is combinational from fixed_en, fixed_sel, full and down_ready. It never depends on up_valid.
- Accept: `up_valid & up_ready`. On the next edge, slot[dst] ← up_data and full[dst] ← 1.
- Drain: `full[k] & down_ready[k]` clears full[k] on the next edge, unless channel k is loaded by an accept in the same cycle. In that case full[k] stays 1 and slot[k] takes the new word.
- down_ready[k] while full[k]=0 has no effect.
- Pointer:
  - advances by 1 only on an accept with fixed_en=0
  - wraps N-1 → 0
  - accepts with fixed_en=1 never move ptr
- Ordering: words sent to the same channel leave in accept order. Each channel holds at most one word.
- Data in a slot is stable while full[k]=1 and down_ready[k]=0.
- Reset (rst=1 at an edge):
  - ptr=0, full=0, every slot=0
  - after the edge: down_valid=0, down_data=0, rr_ptr=0
  - up_ready follows its formula; with ptr=0 and full=0 it is 1
  - reset mid-transfer discards all held words; no down handshake fires for them.

## Timing
- Latency: a word accepted on edge t is visible on down_valid/down_data immediately after edge t, i.e. in cycle t+1. Minimum up→down latency is 1 cycle.
- Throughput:
  - 1 word/cycle when the destination channel is empty or drained in the same cycle
  - round-robin with all down_ready=1: sustained 1 word/cycle, channels filled 0,1,…,N-1,0,…
- Backpressure: if full[dst]=1 and down_ready[dst]=0, up_ready=0 and ptr holds. A stalled channel blocks round-robin traffic; it is not skipped.
- Switching fixed_en/fixed_sel between cycles is allowed. The new destination takes effect in that same cycle's up_ready and accept.
- Simultaneous load and drain on the same channel: the consumer receives the old word; the new word is valid the next cycle, with no bubble.
- No combinational path from up_valid to any output. Paths from down_ready/fixed_* to up_ready are allowed.

## Test plan
- Reset:
  - stimulus: drive rst=1 for 2 cycles with up_valid=1 and up_data=8'hAA; then release rst
  - required: down_valid=4'b0000, down_data=0 and rr_ptr=0 while rst=1; up_ready=1; no accept is recorded during reset
- Round-robin streaming:
  - stimulus: N=4, down_ready=4'b1111, fixed_en=0, words 8'h10..8'h17 back-to-back
  - required: channels receive 10,11,12,13,14,15,16,17 in order 0,1,2,3,0,1,2,3; one word per cycle; rr_ptr returns to 0 after 8 accepts
- Backpressure:
  - stimulus: down_ready[1]=0 with the other channels ready; send 8'h20,8'h21,8'h22,8'h23,8'h24
  - required:
    - 20→ch0, 21→ch1, 22→ch2, 23→ch3, 24→ch0
    - the next word (ptr=1) stalls with up_ready=0 and rr_ptr=1
    - ch1 holds 8'h21 stable
    - raising down_ready[1] releases the stall
- Fixed mode:
  - stimulus: fixed_en=1, fixed_sel=2, words 8'h30,8'h31 with down_ready[2]=1
  - required: both words land on ch2 in order; rr_ptr unchanged
  - stimulus: then fixed_sel=2 with down_ready[2]=0 after 8'h32 is loaded
  - required: up_ready=0
- Simultaneous load/drain:
  - stimulus: ch0 full with 8'h40 and down_ready[0]=1 in the same cycle as an accept of 8'h41 to ch0
  - required: the consumer takes 40; the next cycle down_valid[0]=1 with 41
- Reset mid-operation:
  - stimulus: channels 0–2 full; assert rst for 1 cycle
  - required: down_valid=0 and rr_ptr=0 the next cycle; a following word 8'h50 lands on ch0

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N stream demultiplexer.
// Each accepted upstream word is parked in the holding slot of its destination
// channel. The destination comes from the round-robin pointer or from fixed_sel.
// Every channel holds at most one word. A slot can be reloaded in the same
// cycle it drains, so a busy channel still sustains one word per cycle.
module stream_demux #(
    parameter int  WIDTH = 8,
    parameter int  N     = 4,
    localparam int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    input  logic [WIDTH-1:0]     up_data,
    output logic                 up_ready,
    input  logic                 fixed_en,
    input  logic [SW-1:0]        fixed_sel,
    output logic [N-1:0]         down_valid,
    output logic [N*WIDTH-1:0]   down_data,
    input  logic [N-1:0]         down_ready,
    output logic [SW-1:0]        rr_ptr
);

    // Per-channel holding state and the round-robin pointer.
    logic [WIDTH-1:0] slot_q [N];
    logic [N-1:0]     full_q;
    logic [SW-1:0]    ptr_q;
    logic [SW-1:0]    ptr_d;

    // Destination decode.
    logic [SW-1:0]    dst;
    logic             dst_ok;
    logic [SW-1:0]    dst_idx;
    logic             accept;

    // Pick the destination and derive up_ready. Do not use up_valid here.
    // When N is not a power of two, an out-of-range fixed_sel is refused.
    // dst_idx is clamped so that full_q/down_ready are never indexed past N-1.
    always_comb begin
        dst      = fixed_en ? fixed_sel : ptr_q;
        dst_ok   = (32'(dst) < 32'(N));
        dst_idx  = dst_ok ? dst : '0;
        up_ready = dst_ok & (~full_q[dst_idx] | down_ready[dst_idx]);
        accept   = up_valid & up_ready;
    end

    // The pointer advances only on round-robin accepts and wraps from N-1 to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && !fixed_en) begin
            ptr_d = (ptr_q == SW'(N - 1)) ? '0 : ptr_q + SW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            logic             load;
            logic             full_d;
            logic [WIDTH-1:0] slot_d;

            // A load wins over a drain. The consumer takes the old word in this
            // cycle, and the new word shows up in the next cycle without a bubble.
            always_comb begin
                load   = accept & (dst_idx == SW'(gi));
                full_d = full_q[gi];
                slot_d = slot_q[gi];
                if (load) begin
                    full_d = 1'b1;
                    slot_d = up_data;
                end else if (down_ready[gi]) begin
                    full_d = 1'b0;
                end
            end

            // Channel holding register. Reset discards any word that is held.
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_q[gi] <= 1'b0;
                    slot_q[gi] <= '0;
                end else begin
                    full_q[gi] <= full_d;
                    slot_q[gi] <= slot_d;
                end
            end

            assign down_data[gi*WIDTH +: WIDTH] = slot_q[gi];
        end
    endgenerate

    assign down_valid = full_q;
    assign rr_ptr     = ptr_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux (WIDTH=8, N=4).
// A table of per-cycle vectors holds the inputs and the hand-derived
// expectations: up_ready, the destination channel, down_valid and rr_ptr after
// the edge. A per-channel scoreboard queue receives each accepted word. The
// queue is popped when that channel's down handshake fires, and its head must
// match down_data whenever the channel is full.
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic                 clk;
    logic                 rst;
    logic                 up_valid;
    logic [WIDTH-1:0]     up_data;
    logic                 up_ready;
    logic                 fixed_en;
    logic [1:0]           fixed_sel;
    logic [N-1:0]         down_valid;
    logic [N*WIDTH-1:0]   down_data;
    logic [N-1:0]         down_ready;
    logic [1:0]           rr_ptr;

    stream_demux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .fixed_en   (fixed_en),
        .fixed_sel  (fixed_sel),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_ready (down_ready),
        .rr_ptr     (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       fen;
        logic [1:0] fsel;
        logic [3:0] dready;
        logic       chk_ready;
        logic       exp_ready;
        int         exp_dst;
        logic [3:0] exp_valid;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[N][$];
    int         n_cmp;
    int         n_bad;

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic fe, input logic [1:0] fs, input logic [3:0] dr,
                       input logic ck, input logic er, input int ed,
                       input logic [3:0] ev, input logic [1:0] ep);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.fen = fe; t.fsel = fs;
        t.dready = dr; t.chk_ready = ck; t.exp_ready = er; t.exp_dst = ed;
        t.exp_valid = ev; t.exp_ptr = ep;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        logic [7:0] got;
        logic [7:0] exp_d;
        @(negedge clk);
        rst        = t.rst;
        up_valid   = t.valid;
        up_data    = t.data;
        fixed_en   = t.fen;
        fixed_sel  = t.fsel;
        down_ready = t.dready;
        #1;
        if (t.chk_ready) check("up_ready", idx, 32'(up_ready), 32'(t.exp_ready));
        // Consumer handshakes in this cycle take the head of each queue.
        if (!t.rst) begin
            for (int k = 0; k < N; k++) begin
                if (down_valid[k] && t.dready[k]) begin
                    got = down_data[k*WIDTH +: WIDTH];
                    if (sb_q[k].size() == 0) begin
                        check("unexpected_word", idx, 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        exp_d = sb_q[k].pop_front();
                        check("drain_data", idx, 32'(got), 32'(exp_d));
                    end
                end
            end
        end
        if (t.rst) begin
            for (int k = 0; k < N; k++) sb_q[k].delete();
        end else if (t.valid && t.exp_ready) begin
            sb_q[t.exp_dst].push_back(t.data);
        end
        $display("vec %0d: rst=%0b valid=%0b data=%02h fen=%0b fsel=%0d dready=%04b up_ready=%0b",
                 idx, t.rst, t.valid, t.data, t.fen, t.fsel, t.dready, up_ready);
        @(posedge clk);
        #1;
        check("down_valid", idx, 32'(down_valid), 32'(t.exp_valid));
        check("rr_ptr", idx, 32'(rr_ptr), 32'(t.exp_ptr));
        if (t.rst) check("reset_data", idx, down_data, 32'h0);
        for (int k = 0; k < N; k++) begin
            if (t.exp_valid[k] && sb_q[k].size() != 0) begin
                exp_d = sb_q[k][0];
                check("held_data", idx, 32'(down_data[k*WIDTH +: WIDTH]), 32'(exp_d));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; up_valid = 1'b0; up_data = '0; fixed_en = 1'b0;
        fixed_sel = '0; down_ready = '0;

        //  rst valid data  fen fsel dready  ck rdy dst valid   ptr
        // Reset with a word offered: nothing is accepted.
        add(1, 1, 8'hAA, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
        add(1, 1, 8'hAA, 0, 0, 4'b0000, 1, 1, 0, 4'b0000, 0);
        // Round-robin streaming, all consumers ready.
        add(0, 1, 8'h10, 0, 0, 4'b1111, 1, 1, 0, 4'b0001, 1);
        add(0, 1, 8'h11, 0, 0, 4'b1111, 1, 1, 1, 4'b0010, 2);
        add(0, 1, 8'h12, 0, 0, 4'b1111, 1, 1, 2, 4'b0100, 3);
        add(0, 1, 8'h13, 0, 0, 4'b1111, 1, 1, 3, 4'b1000, 0);
        add(0, 1, 8'h14, 0, 0, 4'b1111, 1, 1, 0, 4'b0001, 1);
        add(0, 1, 8'h15, 0, 0, 4'b1111, 1, 1, 1, 4'b0010, 2);
        add(0, 1, 8'h16, 0, 0, 4'b1111, 1, 1, 2, 4'b0100, 3);
        add(0, 1, 8'h17, 0, 0, 4'b1111, 1, 1, 3, 4'b1000, 0);
        // Backpressure on ch1.
        add(0, 1, 8'h20, 0, 0, 4'b1101, 1, 1, 0, 4'b0001, 1);
        add(0, 1, 8'h21, 0, 0, 4'b1101, 1, 1, 1, 4'b0010, 2);
        add(0, 1, 8'h22, 0, 0, 4'b1101, 1, 1, 2, 4'b0110, 3);
        add(0, 1, 8'h23, 0, 0, 4'b1101, 1, 1, 3, 4'b1010, 0);
        add(0, 1, 8'h24, 0, 0, 4'b1101, 1, 1, 0, 4'b0011, 1);
        add(0, 1, 8'h25, 0, 0, 4'b1101, 1, 0, 1, 4'b0010, 1);
        add(0, 1, 8'h25, 0, 0, 4'b1101, 1, 0, 1, 4'b0010, 1);
        add(0, 1, 8'h25, 0, 0, 4'b1111, 1, 1, 1, 4'b0010, 2);
        // Fixed mode to ch2, then ch2 stalls.
        add(0, 1, 8'h30, 1, 2, 4'b1111, 1, 1, 2, 4'b0100, 2);
        add(0, 1, 8'h31, 1, 2, 4'b1111, 1, 1, 2, 4'b0100, 2);
        add(0, 1, 8'h32, 1, 2, 4'b1111, 1, 1, 2, 4'b0100, 2);
        add(0, 1, 8'h33, 1, 2, 4'b1011, 1, 0, 2, 4'b0100, 2);
        add(0, 0, 8'h00, 1, 2, 4'b1111, 1, 1, 2, 4'b0000, 2);
        // Simultaneous load/drain on ch0.
        add(0, 1, 8'h40, 1, 0, 4'b0000, 1, 1, 0, 4'b0001, 2);
        add(0, 1, 8'h41, 1, 0, 4'b0001, 1, 1, 0, 4'b0001, 2);
        add(0, 0, 8'h00, 1, 0, 4'b0001, 1, 1, 0, 4'b0000, 2);
        // Fill ch0..ch2, then reset mid-operation.
        add(0, 1, 8'h42, 1, 0, 4'b0000, 1, 1, 0, 4'b0001, 2);
        add(0, 1, 8'h43, 1, 1, 4'b0000, 1, 1, 1, 4'b0011, 2);
        add(0, 1, 8'h44, 1, 2, 4'b0000, 1, 1, 2, 4'b0111, 2);
        add(1, 1, 8'h45, 0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0);
        add(0, 1, 8'h50, 0, 0, 4'b0000, 1, 1, 0, 4'b0001, 1);
        add(0, 0, 8'h00, 0, 0, 4'b1111, 1, 1, 1, 4'b0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Every word that was accepted and not discarded by a reset must have drained.
        for (int k = 0; k < N; k++) begin
            check("leftover_words", k, 32'(sb_q[k].size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
